// File: rtl/cla_seq_pkg.sv
// Shared types and constants for the nibble-serial CLA word sequencer.
package cla_seq_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    // Number of slice passes needed to cover a word of the given width.
    function automatic int nibbles_of(input int width);
        return width / NIBBLE_W;
    endfunction

endpackage

// File: rtl/cla_4bit.sv
// Combinational 4-bit carry-lookahead adder slice.
module cla_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g = a & b;
    assign p = a ^ b;

    // Every carry is a flat function of generate/propagate and cin.
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);

    assign sum  = p ^ c[3:0];
    assign cout = c[4];

endmodule

// File: rtl/cla_word_sequencer.sv
// Multi-cycle WIDTH-bit adder: one shared cla_4bit slice is walked over the
// operands LSB nibble first, carry chained through a register.
// Optional build macro: CLA_SEQ_SUB_EN adds a 'sub' port selecting a - b.
module cla_word_sequencer
    import cla_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef CLA_SEQ_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int NIBBLES = nibbles_of(WIDTH);
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;
    logic [IDX_W-1:0]   idx_q, idx_d;

    logic [WIDTH-1:0]   b_cap;
    logic               carry_cap;
    logic [NIBBLE_W-1:0] slice_a, slice_b, slice_sum;
    logic               slice_cout;
    logic               last_nibble;

    // Operand conditioning at capture time: subtraction is a + ~b + 1.
`ifdef CLA_SEQ_SUB_EN
    assign b_cap     = sub ? ~b : b;
    assign carry_cap = sub ? 1'b1 : cin;
`else
    assign b_cap     = b;
    assign carry_cap = cin;
`endif

    assign slice_a     = a_q[NIBBLE_W*idx_q +: NIBBLE_W];
    assign slice_b     = b_q[NIBBLE_W*idx_q +: NIBBLE_W];
    assign last_nibble = (idx_q == LAST_IDX);

    cla_4bit u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    // State register.
    // NOTE: sequential blocks use non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic: accept in IDLE, walk nibbles in RUN, hand off in DONE.
    // NOTE: assign a default first in every always_comb so no path infers a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)    state_d = RUN;
            RUN:     if (last_nibble) state_d = DONE;
            DONE:    if (out_ready)   state_d = IDLE;
            default:                  state_d = IDLE;
        endcase
    end

    // Handshake outputs decoded from the state.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        busy      = (state_q != IDLE);
    end

    // Datapath next-state: operand capture in IDLE, one nibble per RUN cycle.
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b_cap;
                    carry_d = carry_cap;
                    idx_d   = '0;
                end
            end
            RUN: begin
                sum_d[NIBBLE_W*idx_q +: NIBBLE_W] = slice_sum;
                carry_d = slice_cout;
                if (last_nibble) begin
                    cout_d = slice_cout;
                    idx_d  = '0;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            default: ;
        endcase
    end

    // Datapath registers; sum/cout hold through DONE and back into IDLE.
    // NOTE: the result registers are reset too, so no stale or partial sum is visible after rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            idx_q   <= '0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            idx_q   <= idx_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule
